cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the single multi-cycle main memory between the I-cache and D-cache fill paths and the D-cache write-through port. It sits directly downstream of both caches. On a miss it fetches the whole 16-byte block as eight consecutive word reads, streams returned words back with a word index, and pulses done when the block is complete. It also serialises D-cache writes and holds off new grants while stale memory responses may still be in flight.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, memory word width
- WORDS, 8, words per cache block (block = 16 bytes)
- MEM_LAT, 4, cycles from read issue to `mem_rvalid`
---
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  I-cache fill request, level, held until `i_fill_done`
- i_miss_addr  in  16  I-cache missing address
- i_fill_data  out  16  returned word for I-cache
- i_fill_valid  out  1  `i_fill_data` valid this cycle
- i_fill_word  out  3  word index of `i_fill_data`
- i_fill_done  out  1  one-cycle pulse with the 8th I word
- d_miss, d_miss_addr  in  1/16  D-cache fill request/address, same rules as I
- d_fill_data, d_fill_valid, d_fill_word, d_fill_done  out  16/1/3/1  D-cache fill return, same rules as I
- d_wr_req  in  1  D-cache write-through request, level, held until ack
- d_wr_addr, d_wr_data  in  16/16  write address/data
- d_wr_ack  out  1  one-cycle pulse in the cycle the write is issued
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data
- mem_rvalid  in  1  read data valid
- busy  out  1  state != IDLE, or hold counter nonzero

## Operation
- States: HOLD, IDLE, I_FILL, D_FILL, D_WRITE. Reset → HOLD with hold counter = MEM_LAT. Decrement each cycle; go to IDLE when it reaches 0. No grants in HOLD; `mem_rvalid` is ignored.
- IDLE grant order:
  - If `d_wr_req`, go to D_WRITE. Pending D writes always precede a D fill.
  - Else if only one fill is pending, grant it.
  - If both fills are pending, round-robin: grant the one not served last. `last_owner` resets to I, so D wins the first tie.
- D_WRITE: one cycle. `mem_en`=1, `mem_wr`=1, addr/data from the D port, `d_wr_ack`=1. Next state IDLE.
- FILL:
  - Latch base = addr & 16'hFFF0 on grant.
  - Issue counter k=0..7. Each fill cycle while k<8: `mem_en`=1, `mem_wr`=0, `mem_addr`=base+2k.
  - Receive counter r counts `mem_rvalid` only in FILL states. Output the word on the owner's port with word = r.
  - When r=7 and `mem_rvalid`=1, pulse done and go to IDLE.
- Outputs of the non-owner port stay 0. All outputs are registered-state-derived, not combinational from request inputs, except as listed under Timing.
- Arithmetic: addresses wrap modulo 2^16. r and k are 3-bit counters plus a 1-bit "issue finished" flag.

## Timing
- Reset values: all outputs 0 except `busy`=1 (HOLD).
- Fill grant at cycle G (IDLE sampling request). Reads issue in cycles G+1..G+8. Words return at G+1+MEM_LAT..G+8+MEM_LAT. Done fires at G+12 for MEM_LAT=4. IDLE at G+13.
- Write: grant at cycle G, write and ack in G+1, IDLE in G+2.
- One IDLE cycle minimum between operations.
- A request dropped mid-operation does not abort the operation; it completes.
- Reset asserted mid-fill: next cycle HOLD, counters cleared, no done pulse. In-flight data is discarded by the MEM_LAT hold.
- `mem_rvalid` in IDLE or D_WRITE: ignored.
- Simultaneous `d_wr_req`, `d_miss`, `i_miss` in IDLE: write first, then the tie follows the round-robin rule.

## Structure
- Shared package `cache_pkg`: state encoding, WORDS, MEM_LAT, block-offset mask 16'hFFF0, word-index width.
- Sub-module `fill_sequencer`: issue counter, receive counter, base latch, done generation. The arbiter instantiates one and muxes its return to the owner port.

## Test plan
- After reset, `i_miss`=1 with addr 16'h1236 → hold for 4 cycles. Reads to 16'h1230..16'h123E. Eight `i_fill_valid` with word 0..7. `i_fill_done` with word 7. `d_*` outputs stay 0.
- `d_miss` (16'h0042) and `i_miss` (16'h8000) together from IDLE after reset → D served first (base 16'h0040), then I (base 16'h8000). A second tie goes to whichever was not served last.
- `d_wr_req` addr 16'h00A0 data 16'hBEEF with `d_miss` → one write cycle: `mem_wr`=1, `d_wr_ack` pulse. Then the D fill starts after one IDLE cycle.
- `rst_n`=0 in cycle G+5 of a fill → no done. `busy`=1 for 4 cycles after release. Stray `mem_rvalid` in HOLD is not forwarded.
- `mem_rvalid` pulses in IDLE → no `*_fill_valid`.
- Requester deasserts `i_miss` at cycle G+3 → all 8 words and done are still delivered.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants and state encoding for the cache memory arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int C_WORDS      = 8;
  localparam int C_MEM_LAT    = 4;
  localparam int C_WORD_IDX_W = $clog2(C_WORDS);

  localparam logic [15:0] C_BLOCK_MASK = 16'hFFF0;

  localparam int C_STATE_W = 3;
  typedef logic [C_STATE_W-1:0] state_t;

  localparam state_t C_ST_HOLD    = 3'd0;
  localparam state_t C_ST_IDLE    = 3'd1;
  localparam state_t C_ST_I_FILL  = 3'd2;
  localparam state_t C_ST_D_FILL  = 3'd3;
  localparam state_t C_ST_D_WRITE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fill_sequencer
// Description : Issues the word reads of one block fill and tracks returned words
// Revision    : 1.0 - initial release
// ============================================================================
module fill_sequencer
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = C_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic                       active,
  input  logic                       mem_rvalid,
  output logic                       issue_en,
  output logic [ADDR_W-1:0]          issue_addr,
  output logic                       rx_valid,
  output logic [$clog2(WORDS)-1:0]   rx_word,
  output logic                       done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(WORDS - 1);

  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_issue_idx;
  logic [IDX_W-1:0]  r_rx_idx;
  logic              r_issue_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_issue_idx  <= '0;
      r_rx_idx     <= '0;
      r_issue_done <= 1'b0;
    end else if (start) begin
      r_base       <= start_addr & ADDR_W'(C_BLOCK_MASK);
      r_issue_idx  <= '0;
      r_rx_idx     <= '0;
      r_issue_done <= 1'b0;
    end else if (active) begin
      if (!r_issue_done) begin
        r_issue_idx <= r_issue_idx + 1'b1;
        if (r_issue_idx == C_LAST) begin
          r_issue_done <= 1'b1;
        end
      end
      if (mem_rvalid) begin
        r_rx_idx <= r_rx_idx + 1'b1;
      end
    end
  end

  // Words are two bytes wide, so the byte offset is the word index doubled.
  assign issue_en   = active & ~r_issue_done;
  assign issue_addr = r_base + ADDR_W'({r_issue_idx, 1'b0});
  assign rx_valid   = active & mem_rvalid;
  assign rx_word    = r_rx_idx;
  assign done       = rx_valid & (r_rx_idx == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one multi-cycle memory between I/D block fills and D writes
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = C_WORDS,
  parameter int MEM_LAT = C_MEM_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_miss,
  input  logic [ADDR_W-1:0]       i_miss_addr,
  output logic [DATA_W-1:0]       i_fill_data,
  output logic                    i_fill_valid,
  output logic [C_WORD_IDX_W-1:0] i_fill_word,
  output logic                    i_fill_done,
  input  logic                    d_miss,
  input  logic [ADDR_W-1:0]       d_miss_addr,
  output logic [DATA_W-1:0]       d_fill_data,
  output logic                    d_fill_valid,
  output logic [C_WORD_IDX_W-1:0] d_fill_word,
  output logic                    d_fill_done,
  input  logic                    d_wr_req,
  input  logic [ADDR_W-1:0]       d_wr_addr,
  input  logic [DATA_W-1:0]       d_wr_data,
  output logic                    d_wr_ack,
  output logic                    mem_en,
  output logic                    mem_wr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    busy
);

  localparam int HOLD_W = $clog2(MEM_LAT + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_last_d;  // most recent fill went to the D-cache

  logic                    w_fill_req;
  logic                    w_grant_d;
  logic                    w_start;
  logic [ADDR_W-1:0]       w_start_addr;
  logic                    w_seq_active;
  logic                    w_issue_en;
  logic [ADDR_W-1:0]       w_issue_addr;
  logic                    w_rx_valid;
  logic [C_WORD_IDX_W-1:0] w_rx_word;
  logic                    w_done;

  // D wins when it is alone or when I was the last fill owner.
  assign w_fill_req   = i_miss | d_miss;
  assign w_grant_d    = d_miss & (~i_miss | ~r_last_d);
  assign w_start      = (r_state == C_ST_IDLE) & ~d_wr_req & w_fill_req;
  assign w_start_addr = w_grant_d ? d_miss_addr : i_miss_addr;
  assign w_seq_active = (r_state == C_ST_I_FILL) | (r_state == C_ST_D_FILL);

  fill_sequencer #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_fill_sequencer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_start),
    .start_addr (w_start_addr),
    .active     (w_seq_active),
    .mem_rvalid (mem_rvalid),
    .issue_en   (w_issue_en),
    .issue_addr (w_issue_addr),
    .rx_valid   (w_rx_valid),
    .rx_word    (w_rx_word),
    .done       (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= C_ST_HOLD;
      r_hold_cnt <= HOLD_W'(MEM_LAT);
      r_last_d   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (w_start) begin
        r_last_d <= w_grant_d;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_HOLD: begin
        if (r_hold_cnt <= HOLD_W'(1)) begin
          w_next_state = C_ST_IDLE;
        end
      end
      C_ST_IDLE: begin
        if (d_wr_req) begin
          w_next_state = C_ST_D_WRITE;
        end else if (w_fill_req) begin
          w_next_state = w_grant_d ? C_ST_D_FILL : C_ST_I_FILL;
        end
      end
      C_ST_D_WRITE: w_next_state = C_ST_IDLE;
      C_ST_I_FILL, C_ST_D_FILL: begin
        if (w_done) begin
          w_next_state = C_ST_IDLE;
        end
      end
      default: w_next_state = C_ST_HOLD;
    endcase
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    d_wr_ack     = 1'b0;
    i_fill_data  = '0;
    i_fill_valid = 1'b0;
    i_fill_word  = '0;
    i_fill_done  = 1'b0;
    d_fill_data  = '0;
    d_fill_valid = 1'b0;
    d_fill_word  = '0;
    d_fill_done  = 1'b0;
    busy         = (r_state != C_ST_IDLE) | (r_hold_cnt != '0);
    case (r_state)
      C_ST_D_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
      end
      C_ST_I_FILL: begin
        mem_en       = w_issue_en;
        mem_addr     = w_issue_en ? w_issue_addr : '0;
        i_fill_valid = w_rx_valid;
        i_fill_data  = w_rx_valid ? mem_rdata : '0;
        i_fill_word  = w_rx_valid ? w_rx_word : '0;
        i_fill_done  = w_done;
      end
      C_ST_D_FILL: begin
        mem_en       = w_issue_en;
        mem_addr     = w_issue_en ? w_issue_addr : '0;
        d_fill_valid = w_rx_valid;
        d_fill_data  = w_rx_valid ? mem_rdata : '0;
        d_fill_word  = w_rx_valid ? w_rx_word : '0;
        d_fill_done  = w_done;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Directed self-checking bench for cache_mem_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] i_fill_data, d_fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  i_fill_word, d_fill_word;
  logic        i_fill_valid, i_fill_done, d_fill_valid, d_fill_done;
  logic        d_wr_ack, mem_en, mem_wr, mem_rvalid, busy;

  logic        stray_v;
  logic [15:0] stray_d;
  logic [3:0]  pv = 4'b0;
  logic [15:0] pa [4];

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr), .i_fill_data(i_fill_data),
    .i_fill_valid(i_fill_valid), .i_fill_word(i_fill_word), .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr), .d_fill_data(d_fill_data),
    .d_fill_valid(d_fill_valid), .d_fill_word(d_fill_word), .d_fill_done(d_fill_done),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory with 4-cycle read latency; read data is the address XOR A5A5.
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_rvalid = pv[3] | stray_v;
  assign mem_rdata  = stray_v ? stray_d : (pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Entered in grant cycle G; returns in cycle G+13 (IDLE).
  task automatic expect_fill(input bit is_d, input logic [15:0] base, input int drop_at,
                             input string tag);
    logic [15:0] ea;
    logic        ov, odone, nv, ndone;
    logic [2:0]  ow, nw;
    logic [15:0] od, nd;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == drop_at) begin
        if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
      end
      if (is_d) begin
        ov = d_fill_valid; ow = d_fill_word; od = d_fill_data; odone = d_fill_done;
        nv = i_fill_valid; nw = i_fill_word; nd = i_fill_data; ndone = i_fill_done;
      end else begin
        ov = i_fill_valid; ow = i_fill_word; od = i_fill_data; odone = i_fill_done;
        nv = d_fill_valid; nw = d_fill_word; nd = d_fill_data; ndone = d_fill_done;
      end
      checks++;
      if ({mem_en, mem_wr} !== {(c <= 8), 1'b0}) begin
        errors++;
        $display("FAIL %s mem_en/wr G+%0d got %b%b want %b0", tag, c, mem_en, mem_wr, (c <= 8));
      end
      if (c <= 8) begin
        ea = base + 16'(2 * (c - 1));
        checks++;
        if (mem_addr !== ea) begin
          errors++;
          $display("FAIL %s mem_addr G+%0d got %h want %h", tag, c, mem_addr, ea);
        end
      end
      checks++;
      if ({ov, odone} !== {(c >= 5), (c == 12)}) begin
        errors++;
        $display("FAIL %s valid/done G+%0d got %b%b want %b%b", tag, c, ov, odone, (c >= 5), (c == 12));
      end
      if (c >= 5) begin
        ea = (base + 16'(2 * (c - 5))) ^ 16'hA5A5;
        checks++;
        if ({ow, od} !== {3'(c - 5), ea}) begin
          errors++;
          $display("FAIL %s word/data G+%0d got %0d/%h want %0d/%h", tag, c, ow, od, c - 5, ea);
        end
      end
      checks++;
      if ({nv, nw, nd, ndone} !== 21'h0) begin
        errors++;
        $display("FAIL %s other port G+%0d got %b/%0d/%h/%b want 0", tag, c, nv, nw, nd, ndone);
      end
      checks++;
      if ({busy, d_wr_ack} !== 2'b10) begin
        errors++;
        $display("FAIL %s busy/ack G+%0d got %b%b want 10", tag, c, busy, d_wr_ack);
      end
      if (c == 12) begin
        if (is_d) d_miss = 1'b0; else i_miss = 1'b0;
      end
    end
    tick();
    checks++;
    if ({busy, i_fill_valid, d_fill_valid} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle after fill got %b%b%b want 000", tag, busy, i_fill_valid, d_fill_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, i_fill_valid, i_fill_data, i_fill_word,
         i_fill_done, d_fill_valid, d_fill_data, d_fill_word, d_fill_done} !== 77'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset outputs: busy=%b mem_en=%b i_v=%b d_v=%b ack=%b want busy=1 rest 0",
               busy, mem_en, i_fill_valid, d_fill_valid, d_wr_ack);
    end
    for (int h = 0; h < 4; h++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL reset hold busy cycle %0d got %b want 1", h, busy);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_i_fill();
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    apply_reset();
    for (int h = 0; h < 4; h++) begin
      checks++;
      if ({busy, mem_en} !== 2'b10) begin
        errors++;
        $display("FAIL i_fill hold cycle %0d busy/mem_en got %b%b want 10", h, busy, mem_en);
      end
      tick();
    end
    checks++;
    if ({busy, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL i_fill grant cycle busy/mem_en got %b%b want 00", busy, mem_en);
    end
    expect_fill(1'b0, 16'h1230, 0, "i_fill");
  endtask

  task automatic test_tie();
    d_miss = 1'b1; d_miss_addr = 16'h0042;
    i_miss = 1'b1; i_miss_addr = 16'h8000;
    apply_reset();
    repeat (4) tick();
    expect_fill(1'b1, 16'h0040, 0, "tie1_d");
    expect_fill(1'b0, 16'h8000, 0, "tie1_i");
    d_miss = 1'b1; d_miss_addr = 16'h1111;
    i_miss = 1'b1; i_miss_addr = 16'h3337;
    expect_fill(1'b1, 16'h1110, 0, "tie2_d");
    d_miss = 1'b1; d_miss_addr = 16'h0042;
    expect_fill(1'b0, 16'h3330, 0, "tie3_i");
    expect_fill(1'b1, 16'h0040, 0, "tie3_d");
  endtask

  task automatic test_write_priority();
    d_wr_req = 1'b1; d_wr_addr = 16'h00A0; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h0042;
    i_miss = 1'b1; i_miss_addr = 16'hABCD;
    stray_v = 1'b1; stray_d = 16'hDEAD;
    tick();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, busy} !== {2'b11, 16'h00A0, 16'hBEEF, 2'b11}) begin
      errors++;
      $display("FAIL write cycle got en=%b wr=%b a=%h d=%h ack=%b busy=%b want 1 1 00a0 beef 1 1",
               mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack, busy);
    end
    checks++;
    if ({i_fill_valid, d_fill_valid} !== 2'b00) begin
      errors++;
      $display("FAIL write rvalid leak got %b%b want 00", i_fill_valid, d_fill_valid);
    end
    d_wr_req = 1'b0;
    stray_v  = 1'b0;
    tick();
    checks++;
    if ({mem_en, d_wr_ack, busy} !== 3'b000) begin
      errors++;
      $display("FAIL write idle gap got en=%b ack=%b busy=%b want 000", mem_en, d_wr_ack, busy);
    end
    expect_fill(1'b0, 16'hABC0, 0, "wr_then_i");
    expect_fill(1'b1, 16'h0040, 0, "wr_then_d");
  endtask

  task automatic test_idle_rvalid();
    stray_v = 1'b1; stray_d = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({i_fill_valid, d_fill_valid, i_fill_data, d_fill_data, busy} !== 35'h0) begin
        errors++;
        $display("FAIL idle rvalid %0d got iv=%b dv=%b id=%h dd=%h busy=%b want 0",
                 k, i_fill_valid, d_fill_valid, i_fill_data, d_fill_data, busy);
      end
    end
    stray_v = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    i_miss = 1'b1; i_miss_addr = 16'h7776;
    expect_fill(1'b0, 16'h7770, 3, "drop");
  endtask

  task automatic test_reset_mid_fill();
    i_miss = 1'b1; i_miss_addr = 16'h5000;
    for (int c = 1; c <= 5; c++) tick();
    checks++;
    if ({i_fill_valid, i_fill_word, i_fill_data} !== {1'b1, 3'd0, 16'h5000 ^ 16'hA5A5}) begin
      errors++;
      $display("FAIL midrst first word got %b/%0d/%h want 1/0/%h", i_fill_valid, i_fill_word,
               i_fill_data, 16'h5000 ^ 16'hA5A5);
    end
    rst_n  = 1'b0;
    i_miss = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int h = 0; h < 4; h++) begin
      checks++;
      if ({busy, mem_en, i_fill_valid, i_fill_done, d_fill_valid, d_fill_done} !== 6'b100000) begin
        errors++;
        $display("FAIL midrst hold %0d got busy=%b en=%b iv=%b idn=%b dv=%b ddn=%b want 1 0 0 0 0 0",
                 h, busy, mem_en, i_fill_valid, i_fill_done, d_fill_valid, d_fill_done);
      end
      tick();
    end
    checks++;
    if ({busy, i_fill_valid, i_fill_done} !== 3'b000) begin
      errors++;
      $display("FAIL midrst idle got busy=%b iv=%b idn=%b want 000", busy, i_fill_valid, i_fill_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    stray_v = 1'b0; stray_d = '0;
    test_reset();
    test_i_fill();
    test_tie();
    test_write_priority();
    test_idle_rvalid();
    test_drop();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
